// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, 8 data bits LSB-first, optional parity, 1 or 2 stops.
// Parity comes from an external combinational generator fed by the latched byte and mode.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [1:0] parity_type,
  input  logic       stop2,
  output logic [7:0] par_data,
  output logic [1:0] par_type,
  input  logic       par_bit,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          stop2_q, stop2_d;
  logic [7:0]    par_data_q, par_data_d;
  logic [1:0]    par_type_q, par_type_d;
  logic          par_bit_q, par_bit_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_ready_q, tx_ready_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic bit_end;
  logic parity_en;

  assign bit_end   = (cnt_q == CNT_MAX);
  assign parity_en = (par_type_q == 2'b01) || (par_type_q == 2'b10);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    stop2_d    = stop2_q;
    par_data_d = par_data_q;
    par_type_d = par_type_q;
    par_bit_d  = par_bit_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid && tx_ready_q) begin
          par_data_d = tx_data;
          par_type_d = parity_type;
          stop2_d    = stop2;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            stop_cnt_d = 1'b0;
            if (parity_en) begin
              state_d   = S_PARITY;
              par_bit_d = par_bit;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          cnt_d      = '0;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so every output is a flop.
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = par_data_d[idx_d];
      S_PARITY: tx_out_d = par_bit_d;
      default:  tx_out_d = 1'b1;
    endcase
    tx_ready_d   = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_STOP) && (cnt_d == CNT_MAX) && (!stop2_d || stop_cnt_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_cnt_q   <= 1'b0;
      stop2_q      <= 1'b0;
      par_data_q   <= '0;
      par_type_q   <= '0;
      par_bit_q    <= 1'b0;
      tx_out_q     <= 1'b1;
      tx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_cnt_q   <= stop_cnt_d;
      stop2_q      <= stop2_d;
      par_data_q   <= par_data_d;
      par_type_q   <= par_type_d;
      par_bit_q    <= par_bit_d;
      tx_out_q     <= tx_out_d;
      tx_ready_q   <= tx_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_ready   = tx_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign par_data   = par_data_q;
  assign par_type   = par_type_q;

endmodule
